// File: rtl/execute_forwarding_pkg.sv
// ============================================================================
// execute_forwarding_pkg
// Shared FSM state type and stall-counter sizing for the execute forwarding
// control block.
// Revision: 1.0
// ============================================================================
`default_nettype none

package execute_forwarding_pkg;

    localparam int STALL_COUNT_WIDTH = 16;
    localparam logic [STALL_COUNT_WIDTH-1:0] STALL_COUNT_MAX = '1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } fwd_state_t;

endpackage

`default_nettype wire

// File: rtl/execute_forwarding_ctrl_if.sv
// ============================================================================
// execute_forwarding_ctrl_if
// Writeback/load/operand bundle between the execute stage and the forwarding
// controller; master drives the stage side, slave is the controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface execute_forwarding_ctrl_if;
    import execute_forwarding_pkg::*;

    logic                         iFLUSH;
    logic                         iWB_GR_VALID;
    logic [31:0]                  iWB_GR_DATA;
    logic [4:0]                   iWB_GR_DEST;
    logic                         iWB_GR_DEST_SYSREG;
    logic                         iWB_GR_LOAD;
    logic                         iWB_SPR_VALID;
    logic [31:0]                  iWB_SPR_DATA;
    logic                         iWB_FRCR_VALID;
    logic [63:0]                  iWB_FRCR_DATA;
    logic                         iLOAD_ISSUE;
    logic [4:0]                   iLOAD_DEST;
    logic                         iLOAD_DEST_SYSREG;
    logic                         iSRC_VALID;
    logic [4:0]                   iSRC0_POINTER;
    logic [4:0]                   iSRC1_POINTER;
    logic                         iSRC0_SYSREG;
    logic                         iSRC1_SYSREG;
    logic                         iSRC0_IMM;
    logic                         iSRC1_IMM;

    logic                         oPREV_WB_GR_VALID;
    logic [31:0]                  oPREV_WB_GR_DATA;
    logic [4:0]                   oPREV_WB_GR_DEST;
    logic                         oPREV_WB_GR_DEST_SYSREG;
    logic                         oPREV_WB_SPR_VALID;
    logic [31:0]                  oPREV_WB_SPR_DATA;
    logic                         oPREV_WB_FRCR_VALID;
    logic [63:0]                  oPREV_WB_FRCR_DATA;
    logic                         oSTALL;
    logic                         oLOAD_BUSY;
    logic [STALL_COUNT_WIDTH-1:0] oSTALL_COUNT;

    modport master (
        output iFLUSH, iWB_GR_VALID, iWB_GR_DATA, iWB_GR_DEST, iWB_GR_DEST_SYSREG,
               iWB_GR_LOAD, iWB_SPR_VALID, iWB_SPR_DATA, iWB_FRCR_VALID,
               iWB_FRCR_DATA, iLOAD_ISSUE, iLOAD_DEST, iLOAD_DEST_SYSREG,
               iSRC_VALID, iSRC0_POINTER, iSRC1_POINTER, iSRC0_SYSREG,
               iSRC1_SYSREG, iSRC0_IMM, iSRC1_IMM,
        input  oPREV_WB_GR_VALID, oPREV_WB_GR_DATA, oPREV_WB_GR_DEST,
               oPREV_WB_GR_DEST_SYSREG, oPREV_WB_SPR_VALID, oPREV_WB_SPR_DATA,
               oPREV_WB_FRCR_VALID, oPREV_WB_FRCR_DATA, oSTALL, oLOAD_BUSY,
               oSTALL_COUNT
    );

    modport slave (
        input  iFLUSH, iWB_GR_VALID, iWB_GR_DATA, iWB_GR_DEST, iWB_GR_DEST_SYSREG,
               iWB_GR_LOAD, iWB_SPR_VALID, iWB_SPR_DATA, iWB_FRCR_VALID,
               iWB_FRCR_DATA, iLOAD_ISSUE, iLOAD_DEST, iLOAD_DEST_SYSREG,
               iSRC_VALID, iSRC0_POINTER, iSRC1_POINTER, iSRC0_SYSREG,
               iSRC1_SYSREG, iSRC0_IMM, iSRC1_IMM,
        output oPREV_WB_GR_VALID, oPREV_WB_GR_DATA, oPREV_WB_GR_DEST,
               oPREV_WB_GR_DEST_SYSREG, oPREV_WB_SPR_VALID, oPREV_WB_SPR_DATA,
               oPREV_WB_FRCR_VALID, oPREV_WB_FRCR_DATA, oSTALL, oLOAD_BUSY,
               oSTALL_COUNT
    );

endinterface

`default_nettype wire

// File: rtl/execute_forwarding_history.sv
// ============================================================================
// execute_forwarding_history
// One-cycle history of the GR/SPR/FRCR writebacks for late forwarding.
// FRCR history exists only with EXECUTE_FORWARDING_CTRL_FRCR_EN defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module execute_forwarding_history (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        flush,
    input  wire logic        wb_gr_valid,
    input  wire logic [31:0] wb_gr_data,
    input  wire logic [4:0]  wb_gr_dest,
    input  wire logic        wb_gr_dest_sysreg,
    input  wire logic        wb_spr_valid,
    input  wire logic [31:0] wb_spr_data,
    input  wire logic        wb_frcr_valid,
    input  wire logic [63:0] wb_frcr_data,
    output logic             prev_gr_valid,
    output logic [31:0]      prev_gr_data,
    output logic [4:0]       prev_gr_dest,
    output logic             prev_gr_dest_sysreg,
    output logic             prev_spr_valid,
    output logic [31:0]      prev_spr_data,
    output logic             prev_frcr_valid,
    output logic [63:0]      prev_frcr_data
);

    logic        r_gr_valid;
    logic [31:0] r_gr_data;
    logic [4:0]  r_gr_dest;
    logic        r_gr_dest_sysreg;
    logic        r_spr_valid;
    logic [31:0] r_spr_data;

    // Valids always follow the current writeback (cleared by flush); payloads
    // hold their last valid value so a stale entry still reads coherently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gr_valid       <= 1'b0;
            r_gr_data        <= 32'h0;
            r_gr_dest        <= 5'h0;
            r_gr_dest_sysreg <= 1'b0;
            r_spr_valid      <= 1'b0;
            r_spr_data       <= 32'h0;
        end else begin
            r_gr_valid  <= wb_gr_valid && !flush;
            r_spr_valid <= wb_spr_valid && !flush;
            if (wb_gr_valid) begin
                r_gr_data        <= wb_gr_data;
                r_gr_dest        <= wb_gr_dest;
                r_gr_dest_sysreg <= wb_gr_dest_sysreg;
            end
            if (wb_spr_valid) begin
                r_spr_data <= wb_spr_data;
            end
        end
    end

    assign prev_gr_valid       = r_gr_valid;
    assign prev_gr_data        = r_gr_data;
    assign prev_gr_dest        = r_gr_dest;
    assign prev_gr_dest_sysreg = r_gr_dest_sysreg;
    assign prev_spr_valid      = r_spr_valid;
    assign prev_spr_data       = r_spr_data;

`ifdef EXECUTE_FORWARDING_CTRL_FRCR_EN
    logic        r_frcr_valid;
    logic [63:0] r_frcr_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frcr_valid <= 1'b0;
            r_frcr_data  <= 64'h0;
        end else begin
            r_frcr_valid <= wb_frcr_valid && !flush;
            if (wb_frcr_valid) begin
                r_frcr_data <= wb_frcr_data;
            end
        end
    end

    assign prev_frcr_valid = r_frcr_valid;
    assign prev_frcr_data  = r_frcr_data;
`else
    logic w_unused_frcr;

    assign w_unused_frcr   = ^{wb_frcr_valid, wb_frcr_data};
    assign prev_frcr_valid = 1'b0;
    assign prev_frcr_data  = 64'h0;
`endif

endmodule

`default_nettype wire

// File: rtl/execute_forwarding_ctrl.sv
// ============================================================================
// execute_forwarding_ctrl
// Writeback history, single-outstanding-load interlock and stall counter for
// the execute stage. Optional FRCR history: EXECUTE_FORWARDING_CTRL_FRCR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module execute_forwarding_ctrl
    import execute_forwarding_pkg::*;
#(
    // Must track the SPR sysreg index defined in core.h
    parameter logic [4:0] SPR_INDEX = 5'd1
) (
    input  wire logic              iCLOCK,
    input  wire logic              inRESET,
    execute_forwarding_ctrl_if.slave bus
);

    fwd_state_t                   r_state;
    fwd_state_t                   w_state_next;
    logic [4:0]                   r_pend_dest;
    logic [4:0]                   w_pend_dest_next;
    logic                         r_pend_sysreg;
    logic                         w_pend_sysreg_next;
    logic [STALL_COUNT_WIDTH-1:0] r_stall_count;

    logic w_pend;
    logic w_pend_is_spr;
    logic w_gr_return;
    logic w_spr_return;
    logic w_return_match;
    logic w_src0_hit;
    logic w_src1_hit;
    logic w_stall;
    logic w_load_busy;

    execute_forwarding_history u_history (
        .clk                 (iCLOCK),
        .rst_n               (inRESET),
        .flush               (bus.iFLUSH),
        .wb_gr_valid         (bus.iWB_GR_VALID),
        .wb_gr_data          (bus.iWB_GR_DATA),
        .wb_gr_dest          (bus.iWB_GR_DEST),
        .wb_gr_dest_sysreg   (bus.iWB_GR_DEST_SYSREG),
        .wb_spr_valid        (bus.iWB_SPR_VALID),
        .wb_spr_data         (bus.iWB_SPR_DATA),
        .wb_frcr_valid       (bus.iWB_FRCR_VALID),
        .wb_frcr_data        (bus.iWB_FRCR_DATA),
        .prev_gr_valid       (bus.oPREV_WB_GR_VALID),
        .prev_gr_data        (bus.oPREV_WB_GR_DATA),
        .prev_gr_dest        (bus.oPREV_WB_GR_DEST),
        .prev_gr_dest_sysreg (bus.oPREV_WB_GR_DEST_SYSREG),
        .prev_spr_valid      (bus.oPREV_WB_SPR_VALID),
        .prev_spr_data       (bus.oPREV_WB_SPR_DATA),
        .prev_frcr_valid     (bus.oPREV_WB_FRCR_VALID),
        .prev_frcr_data      (bus.oPREV_WB_FRCR_DATA)
    );

    assign w_pend        = (r_state == ST_PEND);
    assign w_pend_is_spr = r_pend_sysreg && (r_pend_dest == SPR_INDEX);

    // A load into the SPR may come back on the SPR writeback port instead of GR.
    assign w_gr_return  = bus.iWB_GR_VALID && bus.iWB_GR_LOAD &&
                          (bus.iWB_GR_DEST == r_pend_dest) &&
                          (bus.iWB_GR_DEST_SYSREG == r_pend_sysreg);
    assign w_spr_return = w_pend_is_spr && bus.iWB_SPR_VALID && bus.iWB_GR_LOAD;
    assign w_return_match = w_pend && (w_gr_return || w_spr_return);

    assign w_src0_hit = !bus.iSRC0_IMM && (bus.iSRC0_POINTER == r_pend_dest) &&
                        (bus.iSRC0_SYSREG == r_pend_sysreg);
    assign w_src1_hit = !bus.iSRC1_IMM && (bus.iSRC1_POINTER == r_pend_dest) &&
                        (bus.iSRC1_SYSREG == r_pend_sysreg);

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            r_state       <= ST_IDLE;
            r_pend_dest   <= 5'h0;
            r_pend_sysreg <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pend_dest   <= w_pend_dest_next;
            r_pend_sysreg <= w_pend_sysreg_next;
        end
    end

    // An issue while already busy is dropped; only a retiring load frees the slot.
    always_comb begin
        w_state_next       = r_state;
        w_pend_dest_next   = r_pend_dest;
        w_pend_sysreg_next = r_pend_sysreg;
        w_stall            = 1'b0;
        w_load_busy        = 1'b0;

        if (bus.iFLUSH) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.iLOAD_ISSUE) begin
                        w_state_next       = ST_PEND;
                        w_pend_dest_next   = bus.iLOAD_DEST;
                        w_pend_sysreg_next = bus.iLOAD_DEST_SYSREG;
                    end
                end
                ST_PEND: begin
                    if (w_return_match) begin
                        if (bus.iLOAD_ISSUE) begin
                            w_pend_dest_next   = bus.iLOAD_DEST;
                            w_pend_sysreg_next = bus.iLOAD_DEST_SYSREG;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end

        if (inRESET && w_pend && !w_return_match) begin
            w_load_busy = 1'b1;
            w_stall     = !bus.iFLUSH && bus.iSRC_VALID && (w_src0_hit || w_src1_hit);
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != STALL_COUNT_MAX)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign bus.oSTALL       = w_stall;
    assign bus.oLOAD_BUSY   = w_load_busy;
    assign bus.oSTALL_COUNT = r_stall_count;

endmodule

`default_nettype wire

// File: doc/execute_forwarding_ctrl.md
EXECUTE_FORWARDING_CTRL -- requirements
Module: execute_forwarding_ctrl

Interface
REQ-001 SHALL have one clock, iCLOCK; reset inRESET is synchronous and active-low.
REQ-002 SHALL have ports, in order:
- iCLOCK  in  1  clock.
- inRESET  in  1  synchronous active-low reset.
- iFLUSH  in  1  pipeline flush.
- iWB_GR_VALID  in  1  current GR writeback.
- iWB_GR_DATA  in  32  current GR writeback data.
- iWB_GR_DEST  in  5  current GR writeback destination.
- iWB_GR_DEST_SYSREG  in  1  current writeback destination is a sysreg.
- iWB_GR_LOAD  in  1  current writeback is load return data.
- iWB_SPR_VALID  in  1  current SPR writeback.
- iWB_SPR_DATA  in  32  current SPR writeback data.
- iWB_FRCR_VALID  in  1  current FRCR writeback.
- iWB_FRCR_DATA  in  64  current FRCR writeback data.
- iLOAD_ISSUE  in  1  load leaves execute this cycle.
- iLOAD_DEST  in  5  issuing load destination.
- iLOAD_DEST_SYSREG  in  1  issuing load destination is a sysreg.
- iSRC_VALID  in  1  instruction in execute needs operands.
- iSRC0_POINTER / iSRC1_POINTER  in  5  operand pointers.
- iSRC0_SYSREG / iSRC1_SYSREG  in  1  operand is a sysreg.
- iSRC0_IMM / iSRC1_IMM  in  1  operand is immediate (never stalls).
- oPREV_WB_GR_VALID, oPREV_WB_GR_DATA[31:0], oPREV_WB_GR_DEST[4:0], oPREV_WB_GR_DEST_SYSREG  out  history GR writeback.
- oPREV_WB_SPR_VALID, oPREV_WB_SPR_DATA[31:0]  out  history SPR writeback.
- oPREV_WB_FRCR_VALID, oPREV_WB_FRCR_DATA[63:0]  out  history FRCR writeback.
- oSTALL  out  1  load-use interlock.
- oLOAD_BUSY  out  1  load already outstanding; a new load must not issue.
- oSTALL_COUNT  out  16  saturating count of stall cycles.

Function
REQ-003 SHALL register each current writeback field into the matching oPREV_WB_* field every cycle, one-cycle latency; data fields SHALL load only when their valid is high, and valids SHALL always load.
REQ-004 SHALL have FSM states IDLE and PEND; IDLE->PEND on iLOAD_ISSUE; PEND->IDLE on a load return match (REQ-005) or iFLUSH.
REQ-005 Load return match: iWB_GR_VALID && iWB_GR_LOAD && iWB_GR_DEST==pending dest && iWB_GR_DEST_SYSREG==pending sysreg flag.
REQ-006 In PEND, SHALL set oSTALL combinationally when iSRC_VALID and any non-IMM operand has pointer/sysreg equal to the pending dest, except in the load-return-match cycle; that cycle SHALL not stall, because current-writeback forwarding covers it.
REQ-007 A pending SPR sysreg dest SHALL also stall on a match against a sysreg SPR operand; iWB_SPR_VALID with iWB_GR_LOAD SHALL count as the return.
REQ-008 oLOAD_BUSY SHALL equal (state==PEND) and not the return-match cycle; iLOAD_ISSUE while busy is a protocol error and is ignored (dest unchanged).
REQ-009 Simultaneous return match and iLOAD_ISSUE in PEND SHALL stay in PEND with the new dest captured.
REQ-010 iFLUSH SHALL clear all oPREV_WB_* valids, force IDLE and drop oSTALL the same cycle; iFLUSH wins over iLOAD_ISSUE.
REQ-011 oSTALL_COUNT SHALL increment on each oSTALL cycle and saturate at 16'hFFFF; flush SHALL not clear it.

Reset
REQ-012 On inRESET low at a clock edge, the block SHALL:
- set the FSM to IDLE;
- clear the pending dest, all oPREV_WB_* valids and data, and oSTALL_COUNT;
- hold oSTALL=0 and oLOAD_BUSY=0 while reset is asserted.
REQ-013 Reset mid-PEND SHALL abandon the outstanding load; a later return SHALL have no effect.

Configuration
REQ-014 Macro EXECUTE_FORWARDING_CTRL_FRCR_EN defined: FRCR history registers per REQ-003.
REQ-015 Macro undefined: oPREV_WB_FRCR_VALID SHALL be tied 0 and oPREV_WB_FRCR_DATA tied 64'h0, with no FRCR flops.

Structure
REQ-016 Package execute_forwarding_pkg SHALL hold the FSM state enum and the stall-counter width constant; sysreg indices (SPR, PSR, FRCR) SHALL remain in core.h.
REQ-017 History registers SHALL be one sub-module, execute_forwarding_history; FSM, compare and counter live in the top module.

Verification
REQ-018 GR writeback dest=5, data=32'hDEADBEEF -> next cycle oPREV_WB_GR_VALID=1, DEST=5, DATA=32'hDEADBEEF; following cycle with no writeback -> VALID=0, DATA held.
REQ-019 Load dest=3; next instruction SRC0=3 for 2 cycles -> oSTALL=1 both cycles, oSTALL_COUNT=2; return dest=3 -> oSTALL=0 that cycle, state IDLE next.
REQ-020 Load dest=3 pending; operand SRC0=3 with IMM=1, or SRC1=4 -> oSTALL=0.
REQ-021 Pending load plus iFLUSH and iLOAD_ISSUE in the same cycle -> IDLE, oLOAD_BUSY=0, oPREV_WB_* valids 0 next cycle.
REQ-022 Force 65535 stall cycles and then 1 more -> oSTALL_COUNT stays 16'hFFFF; reset -> 0.
REQ-023 Build without EXECUTE_FORWARDING_CTRL_FRCR_EN, drive iWB_FRCR_VALID=1 -> oPREV_WB_FRCR_VALID=0 always.
